// File: rtl/mips_mem_pkg.sv
// Shared types and decode helpers for the MIPS Avalon-MM memory port.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    M_NORM = 2'd0,
    M_LWL  = 2'd1,
    M_LWR  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUS  = 3'd1,
    CAPT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Request fields kept for the whole transaction
  typedef struct packed {
    logic        write;
    size_t       size;
    mode_t       mode;
    logic        sgn;
    logic [1:0]  k;
    logic [31:0] rt;
  } req_t;

  // Size code 11 behaves as a word access
  function automatic size_t decode_size(input logic [1:0] raw);
    return (raw == 2'b11) ? SZ_W : size_t'(raw);
  endfunction

  // Stores and the reserved code always use normal lane handling
  function automatic mode_t decode_mode(input logic [1:0] raw, input logic write);
    if (write || raw == 2'b11) return M_NORM;
    return mode_t'(raw);
  endfunction

  function automatic logic is_misaligned(input size_t size, input mode_t mode,
                                         input logic [1:0] k);
    if (mode != M_NORM) return 1'b0;
    case (size)
      SZ_H:    return k[0];
      SZ_W:    return k != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_port_if.sv
// Core request/response and Avalon-MM signals of the memory port.
interface mips_mem_port_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [1:0]        req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_rt;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              err_misalign;
  logic              err_timeout;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_mode, req_addr,
           req_wdata, req_rt, waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, err_misalign, err_timeout,
           address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_mode, req_addr,
           req_wdata, req_rt, waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, err_misalign, err_timeout,
           address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_lane_steer.sv
// Combinational byte-lane steering: store replication, byte enables,
// load extraction/extension and LWL/LWR merge.
module mips_lane_steer
  import mips_mem_pkg::*;
(
  input  size_t       size,
  input  mode_t       mode,
  input  logic [1:0]  k,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rt,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata
);
  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [31:0] shifted;

  // sh_r = 8*k, sh_l = 8*(3-k)
  assign sh_r    = {k, 3'b000};
  assign sh_l    = {~k, 3'b000};
  assign shifted = readdata >> sh_r;

  always_comb begin
    byteenable = 4'hF;
    writedata  = wdata;
    rdata      = readdata;
    case (mode)
      M_LWL: begin
        byteenable = 4'hF >> ~k;
        rdata      = (readdata << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      end
      M_LWR: begin
        byteenable = 4'hF << k;
        rdata      = shifted | (rt & ~(32'hFFFF_FFFF >> sh_r));
      end
      default: begin
        case (size)
          SZ_B: begin
            byteenable = 4'b0001 << k;
            writedata  = {4{wdata[7:0]}};
            rdata      = {{24{sgn & shifted[7]}}, shifted[7:0]};
          end
          SZ_H: begin
            byteenable = 4'b0011 << k;
            writedata  = {2{wdata[15:0]}};
            rdata      = {{16{sgn & shifted[15]}}, shifted[15:0]};
          end
          default: ;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/mips_mem_port.sv
// Avalon-MM master port for the multicycle MIPS core: one load/store per
// handshake, misalignment rejection and optional waitrequest timeout.
module mips_mem_port
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  mips_mem_port_if.master bus
);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state;
  req_t             held;
  req_t             live;
  req_t             sel;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       s_byteenable;
  logic [31:0]      s_writedata;
  logic [31:0]      s_rdata;

  always_comb begin
    live.write = bus.req_write;
    live.size  = decode_size(bus.req_size);
    live.mode  = decode_mode(bus.req_mode, bus.req_write);
    live.sgn   = bus.req_signed;
    live.k     = bus.req_addr[1:0];
    live.rt    = bus.req_rt;
  end

  // Steering sees the incoming request in IDLE, the held one afterwards
  assign sel = (state == IDLE) ? live : held;

  mips_lane_steer u_steer (
    .size       (sel.size),
    .mode       (sel.mode),
    .k          (sel.k),
    .sgn        (sel.sgn),
    .wdata      (bus.req_wdata),
    .rt         (sel.rt),
    .readdata   (bus.readdata),
    .byteenable (s_byteenable),
    .writedata  (s_writedata),
    .rdata      (s_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      held             <= '0;
      cnt              <= '0;
      bus.req_ready    <= 1'b1;
      bus.read         <= 1'b0;
      bus.write        <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.err_misalign <= 1'b0;
      bus.err_timeout  <= 1'b0;
      bus.address      <= '0;
      bus.writedata    <= '0;
      bus.byteenable   <= '0;
    end else begin
      bus.resp_valid   <= 1'b0;
      bus.err_misalign <= 1'b0;
      bus.err_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            held          <= live;
            bus.req_ready <= 1'b0;
            bus.address   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (is_misaligned(live.size, live.mode, live.k)) begin
              state <= ERR;
            end else begin
              state          <= BUS;
              cnt            <= '0;
              bus.read       <= ~bus.req_write;
              bus.write      <= bus.req_write;
              bus.writedata  <= s_writedata;
              bus.byteenable <= s_byteenable;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            state          <= held.write ? DONE : CAPT;
            bus.resp_valid <= held.write;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            bus.read        <= 1'b0;
            bus.write       <= 1'b0;
            state           <= DONE;
            bus.resp_valid  <= 1'b1;
            bus.err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPT: begin
          bus.resp_rdata <= s_rdata;
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        // Rejected request idles one cycle, then reports through DONE
        ERR: begin
          bus.resp_valid   <= 1'b1;
          bus.err_misalign <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mem_port.sv
// Directed, table-driven bench for mips_mem_port acting as core and Avalon slave.
module tb_mips_mem_port;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mips_mem_port_if #(.ADDR_W(32)) bus ();

  mips_mem_port #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] rd_in;
    int          w;
    int          lat;
    int          strobes;
    logic [31:0] addr_o;
    logic [3:0]  be;
    logic [31:0] wd_o;
    logic [31:0] rdata_o;
    logic        mis;
    logic        to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic wr, logic [1:0] sz, logic sg, logic [1:0] md,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rt,
                              logic [31:0] rd, int w, int lat, int strobes,
                              logic [31:0] ao, logic [3:0] be, logic [31:0] wdo,
                              logic [31:0] rdo, logic mis, logic to);
    vec_t v;
    v.name = n; v.wr = wr; v.size = sz; v.sgn = sg; v.mode = md; v.addr = a;
    v.wdata = wd; v.rt = rt; v.rd_in = rd; v.w = w; v.lat = lat; v.strobes = strobes;
    v.addr_o = ao; v.be = be; v.wd_o = wdo; v.rdata_o = rdo; v.mis = mis; v.to = to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and act as the Avalon slave until the response pulse
  task automatic run_vec(input vec_t v);
    int          guard;
    int          cyc;
    int          strobes;
    int          stall_left;
    bit          data_next;
    bit          got;
    bit          unstable;
    logic [31:0] seen_addr;
    logic [31:0] seen_wd;
    logic [3:0]  seen_be;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({v.name, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = v.wr; bus.req_size = v.size;
    bus.req_signed = v.sgn; bus.req_mode = v.mode; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; bus.req_rt = v.rt;
    stall_left = v.w; data_next = 0; got = 0; unstable = 0; cyc = 0; strobes = 0;
    seen_addr = '0; seen_wd = '0; seen_be = '0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h7777_7777;
        bus.req_rt = 32'h6666_6666; bus.req_size = 2'b00; bus.req_mode = 2'b10;
        bus.req_signed = ~v.sgn; bus.req_write = ~v.wr;
      end
      bus.readdata = data_next ? v.rd_in : 32'h5A5A_5A5A;
      data_next = 0;
      bus.waitrequest = 1'b0;
      if (bus.read || bus.write) begin
        if (strobes > 0 && (seen_addr != bus.address || seen_be != bus.byteenable ||
                            seen_wd != bus.writedata)) unstable = 1;
        strobes++;
        seen_addr = bus.address; seen_be = bus.byteenable; seen_wd = bus.writedata;
        if (stall_left > 0) begin
          bus.waitrequest = 1'b1;
          stall_left--;
        end else if (bus.read) begin
          data_next = 1;
        end
      end
      if (bus.resp_valid) got = 1;
    end
    bus.waitrequest = 1'b0;
    chk({v.name, " resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
      chk({v.name, " strobes"}, 32'(strobes), 32'(v.strobes));
      chk({v.name, " address"}, bus.address, v.addr_o);
      chk({v.name, " resp_rdata"}, bus.resp_rdata, v.rdata_o);
      chk({v.name, " err_misalign"}, 32'(bus.err_misalign), 32'(v.mis));
      chk({v.name, " err_timeout"}, 32'(bus.err_timeout), 32'(v.to));
      if (v.strobes > 0) begin
        chk({v.name, " byteenable"}, 32'(seen_be), 32'(v.be));
        chk({v.name, " bus_addr"}, seen_addr, v.addr_o);
        chk({v.name, " stable"}, 32'(unstable), 32'd0);
      end
      if (v.wr && v.strobes > 0) chk({v.name, " writedata"}, seen_wd, v.wd_o);
      @(posedge clk); #1;
      chk({v.name, " pulse_end"}, 32'(bus.resp_valid), 32'd0);
      chk({v.name, " ready_after"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_count;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_mode = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_rt = 0;
    bus.waitrequest = 0; bus.readdata = 0;

    //        name        wr sz    sg md    addr          wdata         rt            readdata      W  lat st addr_o        be       wd_o          rdata_o       mis to
    vecs.push_back(mk("lw_w2",   0, 2'd2, 0, 2'd0, 32'h100, 32'h0, 32'h11223344, 32'hDEADBEEF, 2, 5, 3, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("lb_s",    0, 2'd0, 1, 2'd0, 32'h103, 32'h0, 32'h11223344, 32'h80112233, 0, 3, 1, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk("lbu",     0, 2'd0, 0, 2'd0, 32'h103, 32'h0, 32'h11223344, 32'h80112233, 0, 3, 1, 32'h100, 4'b1000, 32'h0, 32'h00000080, 0, 0));
    vecs.push_back(mk("sh",      1, 2'd1, 0, 2'd0, 32'h102, 32'h0000ABCD, 32'h0, 32'h0, 1, 3, 2, 32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080, 0, 0));
    vecs.push_back(mk("lwl_k1",  0, 2'd2, 0, 2'd1, 32'h101, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 3, 1, 32'h100, 4'b0011, 32'h0, 32'hCCDD3344, 0, 0));
    vecs.push_back(mk("lwr_k1",  0, 2'd2, 0, 2'd2, 32'h101, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 3, 1, 32'h100, 4'b1110, 32'h0, 32'h11AABBCC, 0, 0));
    vecs.push_back(mk("lw_mis",  0, 2'd2, 0, 2'd0, 32'h102, 32'h0, 32'h11223344, 32'h0, 0, 2, 0, 32'h100, 4'b0000, 32'h0, 32'h11AABBCC, 1, 0));
    vecs.push_back(mk("lh_s_k2", 0, 2'd1, 1, 2'd0, 32'h106, 32'h0, 32'h11223344, 32'h9ABC1234, 0, 3, 1, 32'h104, 4'b1100, 32'h0, 32'hFFFF9ABC, 0, 0));
    vecs.push_back(mk("sb_k1",   1, 2'd0, 1, 2'd1, 32'h201, 32'h123456EF, 32'h0, 32'h0, 0, 2, 1, 32'h200, 4'b0010, 32'hEFEFEFEF, 32'hFFFF9ABC, 0, 0));
    vecs.push_back(mk("sw_w3",   1, 2'd2, 0, 2'd0, 32'h300, 32'hCAFEF00D, 32'h0, 32'h0, 3, 5, 4, 32'h300, 4'b1111, 32'hCAFEF00D, 32'hFFFF9ABC, 0, 0));
    vecs.push_back(mk("lw_tmo",  0, 2'd2, 0, 2'd0, 32'h104, 32'h0, 32'h11223344, 32'h12345678, 10, 5, 4, 32'h104, 4'b1111, 32'h0, 32'hFFFF9ABC, 0, 1));
    vecs.push_back(mk("sh_mis",  1, 2'd1, 0, 2'd0, 32'h101, 32'h0000BEEF, 32'h0, 32'h0, 0, 2, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF9ABC, 1, 0));
    vecs.push_back(mk("lwl_k3",  0, 2'd2, 1, 2'd1, 32'h103, 32'h0, 32'h11223344, 32'h01020304, 0, 3, 1, 32'h100, 4'b1111, 32'h0, 32'h01020304, 0, 0));
    vecs.push_back(mk("lwr_k3",  0, 2'd2, 0, 2'd2, 32'h103, 32'h0, 32'h11223344, 32'hAABBCCDD, 0, 3, 1, 32'h100, 4'b1000, 32'h0, 32'h112233AA, 0, 0));
    vecs.push_back(mk("lw_sz3",  0, 2'd3, 0, 2'd0, 32'h108, 32'h0, 32'h11223344, 32'h13579BDF, 0, 3, 1, 32'h108, 4'b1111, 32'h0, 32'h13579BDF, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst strobes", {30'd0, bus.read, bus.write}, 32'd0);
    chk("rst resp", {29'd0, bus.resp_valid, bus.err_misalign, bus.err_timeout}, 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst address", bus.address, 32'd0);
    chk("rst writedata", bus.writedata, 32'd0);
    chk("rst byteenable", 32'(bus.byteenable), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a stalled read
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_mode = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.waitrequest = 1'b1;
    chk("midrst read_on", 32'(bus.read), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst read_off", 32'(bus.read), 32'd0);
    chk("midrst ready", 32'(bus.req_ready), 32'd1);
    chk("midrst rdata", bus.resp_rdata, 32'd0);
    rv_count = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.resp_valid) rv_count++;
    end
    chk("midrst no_resp", 32'(rv_count), 32'd0);
    chk("midrst idle_strobes", {30'd0, bus.read, bus.write}, 32'd0);
    bus.waitrequest = 1'b0;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
